// File: rtl/bus_arbiter2_if.sv
// Two-master / one-slave bus bundle for bus_arbiter2.
//   m0_* / m1_* : master request (addr, wdata, wmask, wen, ren) and response (rdata, done, err)
//   s_*         : slave-side request (addr, wdata, wmask, wen, ren) and response (rdata, done)
//   grant       : one-hot current owner, bit N = master N
// Modport master is the arbiter's view (it masters the slave bus); slave is the opposite view.
interface bus_arbiter2_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;

   logic [ADDR_W-1:0] m0_addr,  m1_addr;
   logic [DATA_W-1:0] m0_wdata, m1_wdata;
   logic [MASK_W-1:0] m0_wmask, m1_wmask;
   logic              m0_wen,   m1_wen;
   logic              m0_ren,   m1_ren;
   logic [DATA_W-1:0] m0_rdata, m1_rdata;
   logic              m0_done,  m1_done;
   logic              m0_err,   m1_err;

   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [MASK_W-1:0] s_wmask;
   logic              s_wen;
   logic              s_ren;
   logic [DATA_W-1:0] s_rdata;
   logic              s_done;

   logic [1:0]        grant;

   modport master (
      input  m0_addr, m0_wdata, m0_wmask, m0_wen, m0_ren,
      input  m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren,
      output m0_rdata, m0_done, m0_err,
      output m1_rdata, m1_done, m1_err,
      output s_addr, s_wdata, s_wmask, s_wen, s_ren,
      input  s_rdata, s_done,
      output grant
   );

   modport slave (
      output m0_addr, m0_wdata, m0_wmask, m0_wen, m0_ren,
      output m1_addr, m1_wdata, m1_wmask, m1_wen, m1_ren,
      input  m0_rdata, m0_done, m0_err,
      input  m1_rdata, m1_done, m1_err,
      input  s_addr, s_wdata, s_wmask, s_wen, s_ren,
      output s_rdata, s_done,
      input  grant
   );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master bus arbiter with round-robin or fixed priority and a per-transaction timeout.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bus_arbiter2_if.master -- master requests in, slave request out,
//          slave response routed back to the granted master, one-hot grant
// Parameters:
//   FIXED_PRIORITY : 1 = master 0 always wins, 0 = round-robin
//   TIMEOUT_CYCLES : granted cycles without s_done before forced completion (1..65535)
module bus_arbiter2 #(
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic           clk,
   input  logic           rst,
   bus_arbiter2_if.master bus
);

   localparam int unsigned WAIT_W = 16;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(TIMEOUT_CYCLES);

   // Encoding doubles as the one-hot grant vector
   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10
   } state_e;

   state_e            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   logic              req0, req1;
   logic              gnt0, gnt1, granted;
   logic              winner;
   logic              own_req, own_wen, own_ren;
   logic [ADDR_W-1:0] own_addr;
   logic [DATA_W-1:0] own_wdata;
   logic [MASK_W-1:0] own_wmask;
   logic              timeout_hit;
   logic              finish;

   assign req0    = bus.m0_wen | bus.m0_ren;
   assign req1    = bus.m1_wen | bus.m1_ren;
   assign gnt0    = (state_q == ST_GRANT0);
   assign gnt1    = (state_q == ST_GRANT1);
   assign granted = gnt0 | gnt1;

   // Arbitration winner (1 = master 1); only consumed when some master is requesting
   always_comb begin
      winner = ~req0;
      if (FIXED_PRIORITY == 0 && req0 && req1) begin
         winner = ~last_grant_q;
      end
   end

   // Select the current owner's request
   always_comb begin
      own_addr  = bus.m0_addr;
      own_wdata = bus.m0_wdata;
      own_wmask = bus.m0_wmask;
      own_wen   = bus.m0_wen;
      own_ren   = bus.m0_ren;
      if (gnt1) begin
         own_addr  = bus.m1_addr;
         own_wdata = bus.m1_wdata;
         own_wmask = bus.m1_wmask;
         own_wen   = bus.m1_wen;
         own_ren   = bus.m1_ren;
      end
   end

   assign own_req     = own_wen | own_ren;
   assign timeout_hit = granted && (wait_q == TIMEOUT_VAL);
   // s_done takes precedence over timeout; a dropped request is an abort, never a completion
   assign finish      = granted && own_req && (bus.s_done || timeout_hit);

   // Next-state and bookkeeping
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wait_d       = wait_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 | req1) begin
               state_d      = winner ? ST_GRANT1 : ST_GRANT0;
               last_grant_d = winner;
               wait_d       = '0;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if (!own_req || finish) begin
               state_d = ST_IDLE;
               wait_d  = '0;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; last_grant resets to 1 so master 0 wins first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         wait_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wait_q       <= wait_d;
      end
   end

   // Slave side: pass-through while granted, strobes suppressed on the timeout cycle
   assign bus.s_addr  = granted ? own_addr  : '0;
   assign bus.s_wdata = granted ? own_wdata : '0;
   assign bus.s_wmask = granted ? own_wmask : '0;
   assign bus.s_wen   = granted & own_wen & ~timeout_hit;
   assign bus.s_ren   = granted & own_ren & ~own_wen & ~timeout_hit;

   // Master side: only the owner sees the response
   assign bus.m0_done  = finish & gnt0;
   assign bus.m1_done  = finish & gnt1;
   assign bus.m0_err   = finish & gnt0 & ~bus.s_done;
   assign bus.m1_err   = finish & gnt1 & ~bus.s_done;
   assign bus.m0_rdata = (finish && gnt0 && bus.s_done) ? bus.s_rdata : '0;
   assign bus.m1_rdata = (finish && gnt1 && bus.s_done) ? bus.s_rdata : '0;

   assign bus.grant = {gnt1, gnt0};

endmodule

// File: doc/bus_arbiter2.md
BUS_ARBITER2 -- requirements
Module: bus_arbiter2

Interface
REQ-001 The block SHALL have a parameter FIXED_PRIORITY, default 0, where 1 means master 0 always wins and 0 means round-robin.
REQ-002 The block SHALL have a parameter TIMEOUT_CYCLES, default 1023, giving the granted cycles without s_done before forced completion; valid range 1..65535.
REQ-003 The block SHALL have: clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-005 For N=0,1 the block SHALL have: mN_addr  input  32  byte address.
REQ-006 For N=0,1 the block SHALL have: mN_wdata  input  32  write data, already lane-aligned.
REQ-007 For N=0,1 the block SHALL have: mN_wmask  input  4  byte-lane write mask.
REQ-008 For N=0,1 the block SHALL have: mN_wen / mN_ren  input  1 each  write/read request, held until mN_done.
REQ-009 For N=0,1 the block SHALL have: mN_rdata  output  32  read data, valid only when mN_done=1.
REQ-010 For N=0,1 the block SHALL have: mN_done  output  1  one-cycle completion pulse.
REQ-011 For N=0,1 the block SHALL have: mN_err  output  1  timeout flag, coincident with mN_done.
REQ-012 The block SHALL have: s_addr, s_wdata, s_wmask, s_wen, s_ren  output  32/32/4/1/1  slave-side request.
REQ-013 The block SHALL have: s_rdata  input  32  slave read data, and s_done  input  1  slave completion.
REQ-014 The block SHALL have: grant  output  2  one-hot current owner (bit N = master N); 00 when idle.

Function
REQ-015 The block SHALL treat master N as requesting when mN_wen|mN_ren=1; wen and ren together SHALL be a write.
REQ-016 The FSM SHALL use states IDLE, GRANT0 and GRANT1; transitions SHALL be registered.
REQ-017 In IDLE with any request, the block SHALL enter GRANTn for the winner on the next edge; in IDLE with no request it SHALL stay in IDLE.
REQ-018 Round-robin SHALL give priority to the master not granted last (last_grant register); after reset master 0 SHALL have priority; with one requester, that requester SHALL win.
REQ-019 In GRANTn, s_* SHALL equal master n's signals combinationally; outside GRANT, s_wen=s_ren=0 and s_addr/s_wdata/s_wmask=0.
REQ-020 In GRANTn with s_done=1: mn_done=1, mn_rdata=s_rdata and mn_err=0 in the same cycle, and the FSM SHALL go to IDLE on the next edge.
REQ-021 The non-granted master SHALL see done=0, err=0 and rdata=0; its request SHALL be held pending, not dropped.
REQ-022 Request latency from IDLE SHALL be 1 cycle (request at edge t, slave strobe visible after edge t+1); every transaction SHALL be followed by one IDLE turnaround cycle.
REQ-023 A 16-bit wait counter SHALL clear on grant entry and increment each GRANT cycle without s_done.
REQ-024 When the wait counter reaches TIMEOUT_CYCLES: mn_done=1, mn_err=1, mn_rdata=0, slave strobes forced to 0 that cycle, and the FSM SHALL go to IDLE.
REQ-025 On the cycle both s_done and timeout hold, s_done SHALL win (normal completion, err=0).
REQ-026 If the granted master drops wen|ren before done (abort), the FSM SHALL return to IDLE on the next edge with no done pulse.
REQ-027 last_grant SHALL update on grant entry; when FIXED_PRIORITY=1, last_grant SHALL be ignored.
REQ-028 s_done while in IDLE SHALL be ignored.

Reset
REQ-029 On rst=1 the block SHALL immediately, asynchronously, enter IDLE, set grant=00, last_grant=1 (master 0 next), and set wait counter=0.
REQ-030 During reset all outputs SHALL be 0 (s_*, mN_done, mN_err, mN_rdata).
REQ-031 Reset asserted mid-transaction SHALL drop slave strobes in the same cycle with no done pulse to the master; operation SHALL resume from IDLE after rst deasserts.

Verification
REQ-032 Single read: m0_ren=1 with addr 0x100, slave s_done=1 on the 2nd granted cycle with s_rdata=0xDEADBEEF -> grant=01 one cycle after the request, m0_done pulses once with m0_rdata=0xDEADBEEF, then one IDLE cycle.
REQ-033 Contention in round-robin: m0 and m1 request continuously, slave done after 1 cycle -> grants alternate 01,10,01,10 with an IDLE cycle between each; with FIXED_PRIORITY=1 the sequence is 01,01,...
REQ-034 Write pass-through: m1_wen=1 with wdata 0x12345678 and wmask 0100 -> s_wdata/s_wmask match exactly while grant=10, and m1_rdata=0 at done.
REQ-035 Timeout: TIMEOUT_CYCLES=4 with a slave that never sends done -> m0_done=m0_err=1 after the 4th wait cycle, and s_ren=0 that cycle; then s_done and timeout together in a second run -> err=0.
REQ-036 Reset mid-grant: assert rst while grant=10 -> grant=00 and s_wen=0 before the next clock edge, no m1_done pulse, and master 0 wins the first arbitration after reset.
